// File: rtl/spi_master_txrx.sv
// rtl/spi_master_txrx.sv - SPI mode-0 full-duplex shift engine driven by clkgen rise/fall strobes.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first transmit/receive order (default MSB-first).
module spi_master_txrx #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              spi_rise,
  input  logic              spi_fall,
  output logic              clk_en,
  output logic              sdo,
  input  logic              sdi,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [LEN_W-1:0]  bits_left;
  logic [LEN_W-1:0]  len_eff;
  logic              rise_seen;
  logic              load;
  logic              load_bit;
  logic              fall_bit;

  assign len_eff = (tx_len == '0 || tx_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : tx_len;

  // Gated by rstn so tx_ready reads low while reset is held.
  assign tx_ready = rstn && (state == IDLE);
  assign clk_en   = (state == XFER);
  assign busy     = (state != IDLE);
  assign load     = tx_valid && tx_ready;

`ifdef SPI_LSB_FIRST_EN
  localparam int IDX_W = $clog2(DATA_W);
  logic [DATA_W-1:0] rx_shift;
  logic [LEN_W-1:0]  len_r;
  logic [IDX_W-1:0]  ins_idx;

  // First sampled bit walks down from len_eff-1 and finishes in bit 0.
  assign ins_idx  = IDX_W'(len_r - LEN_W'(1));
  assign rx_next  = (rx_shift >> 1) | ({{(DATA_W-1){1'b0}}, sdi} << ins_idx);
  assign load_bit = tx_data[0];
  assign fall_bit = tx_shift[1];
`else
  localparam int IDX_W = $clog2(DATA_W);
  logic [DATA_W-2:0] rx_shift;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  fall_idx;

  assign load_idx = IDX_W'(len_eff - LEN_W'(1));
  // After k rises bits_left = len-k, so the next bit to present is bits_left-1.
  assign fall_idx = IDX_W'(bits_left - LEN_W'(1));
  assign rx_next  = {rx_shift, sdi};
  assign load_bit = tx_data[load_idx];
  assign fall_bit = tx_shift[fall_idx];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (load) state_d = XFER;
      XFER: if (spi_rise && bits_left == LEN_W'(1)) state_d = DONE;
      DONE: if (rx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      bits_left <= '0;
      rise_seen <= 1'b0;
      sdo       <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      len_r     <= '0;
`endif
    end else if (load) begin
      tx_shift  <= tx_data;
      rx_shift  <= '0;
      bits_left <= len_eff;
      rise_seen <= 1'b0;
      sdo       <= load_bit;
`ifdef SPI_LSB_FIRST_EN
      len_r     <= len_eff;
`endif
    end else if (state == XFER) begin
      // Rise wins if clkgen ever emits both strobes together.
      if (spi_rise) begin
`ifdef SPI_LSB_FIRST_EN
        rx_shift  <= rx_next;
`else
        rx_shift  <= rx_next[DATA_W-2:0];
`endif
        bits_left <= bits_left - LEN_W'(1);
        rise_seen <= 1'b1;
        if (bits_left == LEN_W'(1)) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end else if (spi_fall && rise_seen && bits_left != '0) begin
        sdo <= fall_bit;
`ifdef SPI_LSB_FIRST_EN
        tx_shift <= tx_shift >> 1;
`endif
      end
    end else if (state == DONE && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_txrx.sv
// tb/tb_spi_master_txrx.sv - directed bench for spi_master_txrx with a behavioural clkgen model.
module tb_spi_master_txrx;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [LEN_W-1:0]  tx_len = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic              spi_rise = 1'b0;
  logic              spi_fall = 1'b0;
  logic              clk_en;
  logic              sdo;
  logic              sdi;
  logic              busy;

  logic        lb = 1'b0;
  logic        sdi_val = 1'b0;
  logic        sclk = 1'b0;
  logic [31:0] seq = '0;
  int          rise_cnt = 0;
  int          rise_cyc = 0;
  int          cyc = 0;
  int          div = 0;
  int          base = 0;
  int          passed = 0;
  int          total = 0;

  assign sdi = lb ? sdo : sdi_val;

  spi_master_txrx #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_len(tx_len), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_rise(spi_rise), .spi_fall(spi_fall), .clk_en(clk_en), .sdo(sdo), .sdi(sdi),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // clkgen model: half-period of 2 clk cycles; emits a trailing fall if en drops while sclk is high.
  always @(negedge clk) begin
    spi_rise = 1'b0;
    spi_fall = 1'b0;
    if (clk_en) begin
      div++;
      if (div == 2) begin
        div = 0;
        if (!sclk) begin
          sclk = 1'b1;
          spi_rise = 1'b1;
          rise_cnt++;
          rise_cyc = cyc;
          seq = {seq[30:0], sdo};
        end else begin
          sclk = 1'b0;
          spi_fall = 1'b1;
        end
      end
    end else begin
      div = 0;
      if (sclk) begin
        sclk = 1'b0;
        spi_fall = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start(input string tag, input logic [31:0] d, input logic [LEN_W-1:0] l);
    @(negedge clk);
    check({tag, "_tx_ready"}, tx_ready, 1);
    tx_data  = d;
    tx_len   = l;
    tx_valid = 1'b1;
    base     = rise_cnt;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!rx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, rx_valid, 1);
  endtask

  task automatic release_rx(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check({tag, "_release"}, {29'd0, busy, tx_ready, rx_valid}, 32'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    logic seen_rx;
    int   n;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {27'd0, tx_ready, rx_valid, clk_en, sdo, busy}, 32'd0);
    check("reset_rx_data", rx_data, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);

    // 8-bit loopback; 0xA5 is bit-symmetric so the sdo order matches in either build
    lb = 1'b1;
    start("a5", 32'hA5, 6'd8);
    wait_done("a5");
    check("a5_rx_data", rx_data, 32'h0000_00A5);
    check("a5_rises", rise_cnt - base, 8);
    check("a5_sdo_seq", {24'd0, seq[7:0]}, 32'hA5);
    release_rx("a5");

    // Full word via tx_len=0, sdi tied high
    lb = 1'b0;
    sdi_val = 1'b1;
    start("full", 32'hDEAD_BEEF, 6'd0);
    wait_done("full");
    check("full_rx_data", rx_data, 32'hFFFF_FFFF);
    check("full_rises", rise_cnt - base, 32);
    @(negedge clk);
    check("trail_fall_emitted", {31'd0, sclk}, 0);
    check("trail_state", {29'd0, sdo, busy, clk_en}, 32'b110);

    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(rx_valid && rx_data == 32'hFFFF_FFFF && !tx_ready && !clk_en && busy)) stable = 1'b0;
    end
    check("backpressure_hold", {31'd0, stable}, 1);
    release_rx("full");

    // Length 1, accepted right after the DONE exit
    sdi_val = 1'b0;
    start("len1", 32'h1, 6'd1);
    wait_done("len1");
    check("len1_rx_data", rx_data, 32'd0);
    check("len1_rises", rise_cnt - base, 1);
    check("len1_done_latency", cyc - rise_cyc, 1);
    release_rx("len1");

    // Over-length clamps to DATA_W
    sdi_val = 1'b1;
    start("over", 32'h0, 6'd40);
    wait_done("over");
    check("over_rises", rise_cnt - base, 32);
    check("over_rx_data", rx_data, 32'hFFFF_FFFF);
    release_rx("over");

    // Bit order: 0x01 loopback
    lb = 1'b1;
    start("ord", 32'h01, 6'd8);
    wait_done("ord");
    check("ord_rx_data", rx_data, 32'h01);
`ifdef SPI_LSB_FIRST_EN
    check("ord_sdo_seq", {24'd0, seq[7:0]}, 32'h80);
`else
    check("ord_sdo_seq", {24'd0, seq[7:0]}, 32'h01);
`endif
    release_rx("ord");

    // Reset at bit 5 of a 16-bit transfer
    lb = 1'b0;
    sdi_val = 1'b1;
    start("rst", 32'hFFFF, 6'd16);
    n = 0;
    while (rise_cnt - base < 5 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_reached_bit5", rise_cnt - base, 5);
    rstn = 1'b0;
    #1;
    check("rst_async", {28'd0, clk_en, sdo, busy, rx_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_idle", {30'd0, tx_ready, busy}, 32'b10);
    seen_rx = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rx_valid) seen_rx = 1'b1;
    end
    check("rst_no_rx_valid", {31'd0, seen_rx}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master_txrx.md
Name: spi_master_txrx

Overview:
Full-duplex shift engine for the APB-to-SPI master. It sits directly downstream of the SPI clock generator and consumes that block's spi_rise/spi_fall strobes. It also drives the generator's en input. Per transfer it shifts a word of up to DATA_W bits out on sdo and samples the same number of bits from sdi, using SPI mode 0 (sdo changes on fall, sdi sampled on rise). Word handshakes face the APB register/FIFO side.

Parameters:
DATA_W, 32, maximum transfer length in bits.
LEN_W, 6, width of the length field; must satisfy 2**LEN_W > DATA_W.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to transmit; right-aligned, bits [len-1:0] used
tx_len  input  LEN_W  transfer length in bits, sampled with tx_data
tx_valid  input  1  tx_data/tx_len valid
tx_ready  output  1  engine accepts tx word this cycle
rx_data  output  DATA_W  received word, right-aligned, upper bits zero
rx_valid  output  1  rx_data valid
rx_ready  input  1  consumer accepts rx_data
spi_rise  input  1  one-cycle strobe from clkgen: spi_clk rising
spi_fall  input  1  one-cycle strobe from clkgen: spi_clk falling
clk_en  output  1  drives clkgen en
sdo  output  1  serial data out
sdi  input  1  serial data in
busy  output  1  high in any state except IDLE

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values: state=IDLE, tx_ready=0, rx_valid=0, rx_data=0, clk_en=0, sdo=0, busy=0, and all internal counters and shift registers cleared.
- Reset mid-transfer aborts immediately. No rx_valid is produced for the aborted word.
- States: IDLE, XFER, DONE.
- IDLE: tx_ready=1 (combinational from state).
  - On tx_valid&&tx_ready: load tx_shift<=tx_data, clear rx_shift, set bits_left<=len_eff. Go to XFER next cycle.
  - len_eff = (tx_len==0 || tx_len>DATA_W) ? DATA_W : tx_len.
  - sdo drives tx_data[len_eff-1] registered on the load edge, so the first bit is valid before the first rise.
- XFER: clk_en=1.
  - spi_rise: rx_shift <= {rx_shift[DATA_W-2:0], sdi}; bits_left decrements.
  - If bits_left==1 at that rise (last bit): clk_en drops next cycle, rx_data<=rx_shift with the new bit, rx_valid<=1, go to DONE.
  - spi_fall with bits_left>0 and not the first edge: sdo<=next bit, MSB-first within [len_eff-1:0].
  - A fall before the first rise is ignored, because the bit is already presented.
- DONE: clk_en=0, tx_ready=0.
  - Hold rx_valid and rx_data stable until rx_valid&&rx_ready, then rx_valid<=0 and go to IDLE.
  - sdo holds its last value.
- Strobes outside XFER are ignored. This includes the trailing spi_fall that clkgen emits after en drops while spi_clk is high.
- spi_rise and spi_fall asserted in the same cycle is illegal from clkgen. If it occurs, rise is processed and fall ignored.
- Back-to-back transfers: minimum 1 IDLE cycle between DONE exit and the next load.
- Length 1: exactly one rise; rx_data=={{DATA_W-1{0}},sdi}.
- bits_left is LEN_W bits wide; no wrap is possible because it is loaded at 1..DATA_W.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: transmit tx_data[0] first, ascending to [len_eff-1]. Received bits fill rx_data from bit len_eff-1 downward, so the first sampled bit lands in bit 0 and the result stays right-aligned.
- Undefined: MSB-first as above.

Test Plan:
- Reset mid-XFER: assert rstn=0 at bit 5 of a 16-bit transfer -> clk_en=0, sdo=0, state IDLE, tx_ready=1 after release, no rx_valid.
- 8-bit loopback with sdi=sdo, tx_data=0xA5, tx_len=8 -> sdo sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5, rx_valid=1; exactly 8 spi_rise counted while clk_en=1.
- Full word with tx_len=0, tx_data=0xDEADBEEF, sdi tied 1 -> 32 rises, rx_data=0xFFFFFFFF; trailing spi_fall after clk_en drop leaves sdo and state unchanged.
- Length 1 with tx_data=0x1, sdi=0 -> single rise, rx_data=0, DONE reached one cycle after that rise.
- Backpressure with rx_ready=0 for 20 cycles after DONE -> rx_valid and rx_data stable, tx_ready=0, clk_en=0; release -> IDLE next cycle; a second tx_valid is accepted then.
- SPI_LSB_FIRST_EN defined, tx_data=0x01, len=8, loopback -> sdo sequence 1,0,0,0,0,0,0,0; rx_data=0x01.
